// File: rtl/even_sum_pkg.sv
// Shared types and defaults for the even-number summation scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package even_sum_pkg;

    localparam int NW_DEF = 4;
    localparam int SW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/even_sum_sched_rr_arb2.sv
// Two-input round-robin arbiter with a registered priority pointer.
// Latency: grant is combinational from req; pointer updates on the edge where adv is high.
// Backpressure: none; a requester simply keeps req high until it is granted.
module rr_arb2
    import even_sum_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt,
    output req_id_t    gid
);

    req_id_t ptr;

    // Pointer breaks ties only; a lone request wins regardless of it.
    always_comb begin
        gnt = 2'b00;
        gid = 1'b0;
        if (req[0] && req[1]) begin
            gid = ptr;
            gnt = ptr ? 2'b10 : 2'b01;
        end else if (req[1]) begin
            gid = 1'b1;
            gnt = 2'b10;
        end else if (req[0]) begin
            gid = 1'b0;
            gnt = 2'b01;
        end
    end

    // After each grant, priority passes to the requester that was not served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (adv && (|req)) begin
            ptr <= ~gid;
        end
    end

endmodule

// File: rtl/even_sum_sched.sv
// Shared multi-cycle engine computing 0+2+...+2(N-1), one term per clock; optional EVEN_SUM_SAT_EN saturates and adds ovf.
// Latency: ack one cycle after accept, done N+1 cycles after ack; N+3 cycles per job.
// Backpressure: requests are only accepted in IDLE; requesters hold req until their ack.
module even_sum_sched
    import even_sum_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [NW-1:0] n0,
    input  logic          req1,
    input  logic [NW-1:0] n1,
    output logic          ack0,
    output logic          ack1,
    output logic          busy,
    output logic          done,
    output logic          id,
    output logic [SW-1:0] sum
`ifdef EVEN_SUM_SAT_EN
    ,
    output logic          ovf
`endif
);

    state_t        state;
    state_t        nstate;
    logic [NW-1:0] n_lat;
    logic [NW-1:0] cnt;
    logic [SW-1:0] acc;
    logic [SW-1:0] acc_nxt;
    logic [1:0]    gnt;
    req_id_t       gid;
    logic          accept;
    logic          last;
    logic          ack0_d;
    logic          ack1_d;
    logic          done_d;
    logic          busy_d;

    assign accept = (state == ST_IDLE) && (|gnt);
    assign last   = (cnt == n_lat);

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1, req0}),
        .adv (accept),
        .gnt (gnt),
        .gid (gid)
    );

`ifdef EVEN_SUM_SAT_EN
    // One bit of headroom above both operands so a carry out of SW bits is visible.
    localparam int AW = ((SW > NW + 1) ? SW : NW + 1) + 1;

    logic [AW-1:0] add_ext;
    logic          sat_hit;
    logic          sat_flag;

    // Clamp the running sum at all-ones when the add carries past SW bits.
    always_comb begin
        add_ext = AW'(acc) + AW'({cnt, 1'b0});
        sat_hit = (add_ext[AW-1:SW] != '0);
        acc_nxt = sat_hit ? {SW{1'b1}} : add_ext[SW-1:0];
    end
`else
    // Plain modulo-2^SW accumulation.
    always_comb begin
        acc_nxt = acc + SW'({cnt, 1'b0});
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state logic: DONE always lasts exactly one cycle.
    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: if (accept) nstate = ST_RUN;
            ST_RUN:  if (last)   nstate = ST_DONE;
            ST_DONE:             nstate = ST_IDLE;
            default:             nstate = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered handshake/status outputs.
    always_comb begin
        ack0_d = accept && gnt[0];
        ack1_d = accept && gnt[1];
        done_d = (state == ST_RUN) && last;
        busy_d = (nstate != ST_IDLE);
    end

    // Registered outputs; sum and id only change at done and accept respectively.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
            id   <= 1'b0;
            sum  <= '0;
        end else begin
            ack0 <= ack0_d;
            ack1 <= ack1_d;
            done <= done_d;
            busy <= busy_d;
            if (accept) id  <= gid;
            if (done_d) sum <= acc;
        end
    end

    // Job datapath: latch N on accept, then add one even term per RUN cycle until cnt reaches N.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat <= '0;
            cnt   <= '0;
            acc   <= '0;
        end else if (accept) begin
            n_lat <= gid ? n1 : n0;
            cnt   <= '0;
            acc   <= '0;
        end else if ((state == ST_RUN) && !last) begin
            acc   <= acc_nxt;
            cnt   <= cnt + 1'b1;
        end
    end

`ifdef EVEN_SUM_SAT_EN
    // Sticky per-job saturation flag, published as ovf alongside done.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            sat_flag <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if ((state == ST_RUN) && !last) sat_flag <= sat_flag | sat_hit;
            if (done_d)                     ovf      <= sat_flag;
        end
    end
`endif

endmodule
